gen_big_field_table_main: RTL and testbench

- Transmit-side counterpart of the big-field table parser.
- Takes a wide field value (for example, the header image of a common_frame_table) and emits it as the first FIELD_LEN beats of an AXI-stream frame.
- Then passes a payload stream through until that payload's tlast.
- Sits in front of any stage that consumes framed tables, so a parser at the far end recovers the same value.

---
 rtl/gen_big_field_pkg.sv | 25 ++
 rtl/gen_big_field_table_main_serializer.sv | 50 +++++
 rtl/gen_big_field_table_main.sv | 95 +++++++++
 tb/tb_gen_big_field_table_main.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/gen_big_field_pkg.sv
// Shared types and helpers for the big-field frame generator: FSM states,
// beat index sizing, and the MSB-first beat slicer.
package gen_big_field_pkg;

  typedef enum logic [1:0] {IDLE, HEAD, BODY} state_t;

  localparam int MAX_DSIZE     = 64;
  localparam int MAX_FIELD_LEN = 128;
  localparam int MAX_BITS      = MAX_DSIZE * MAX_FIELD_LEN;

  function automatic int vsize_of(input int field_len);
    return (field_len > 2) ? $clog2(field_len) : 1;
  endfunction

  // Beat 0 is the most-significant slice; caller keeps the low dsize bits.
  function automatic logic [MAX_DSIZE-1:0] beat_of(input logic [MAX_BITS-1:0] shadow,
                                                   input int dsize,
                                                   input int field_len,
                                                   input int index);
    logic [MAX_BITS-1:0] sh;
    sh = shadow >> ((field_len - 1 - index) * dsize);
    return sh[MAX_DSIZE-1:0];
  endfunction

endpackage

// File: rtl/gen_big_field_table_main_serializer.sv
// big_field_serializer: shadow copy of the field image plus the header beat
// index; presents the current beat and flags the final header beat.
module big_field_serializer
  import gen_big_field_pkg::*;
#(
  parameter int DSIZE     = 8,
  parameter int FIELD_LEN = 16
) (
  input  logic                       clock,
  input  logic                       rst,
  input  logic                       load,
  input  logic                       advance,
  input  logic [DSIZE*FIELD_LEN-1:0] value,
  output logic [DSIZE-1:0]           beat,
  output logic                       last_beat
);

  localparam int W     = DSIZE * FIELD_LEN;
  localparam int VSIZE = vsize_of(FIELD_LEN);

  logic [W-1:0]         shadow;
  logic [VSIZE-1:0]     index;
  logic [MAX_BITS-1:0]  ext;
  logic [MAX_DSIZE-1:0] full;
  logic                 unused_hi;

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      shadow <= '0;
      index  <= '0;
    end else if (load) begin
      shadow <= value;
      index  <= '0;
    end else if (advance) begin
      index <= last_beat ? '0 : index + VSIZE'(1);
    end
  end

  assign last_beat = (index == VSIZE'(FIELD_LEN - 1));

  always_comb begin
    ext        = '0;
    ext[W-1:0] = shadow;
    full       = beat_of(ext, DSIZE, FIELD_LEN, int'(index));
  end

  assign beat      = full[DSIZE-1:0];
  assign unused_hi = ^(full >> DSIZE);

endmodule

// File: rtl/gen_big_field_table_main.sv
// Frame generator: emits a latched wide field as FIELD_LEN header beats, then
// passes one payload frame through. GEN_BIG_FIELD_HEAD_ONLY_EN adds value_last.
module gen_big_field_table_main
  import gen_big_field_pkg::*;
#(
  parameter int DSIZE     = 8,
  parameter int FIELD_LEN = 16
) (
  input  logic                       clock,
  input  logic                       rst,
  input  logic [DSIZE*FIELD_LEN-1:0] value,
  input  logic                       value_valid,
`ifdef GEN_BIG_FIELD_HEAD_ONLY_EN
  input  logic                       value_last,
`endif
  output logic                       value_ready,
  input  logic [DSIZE-1:0]           s_axis_tdata,
  input  logic                       s_axis_tvalid,
  input  logic                       s_axis_tlast,
  output logic                       s_axis_tready,
  output logic [DSIZE-1:0]           m_axis_tdata,
  output logic                       m_axis_tvalid,
  output logic                       m_axis_tlast,
  input  logic                       m_axis_tready
);

  state_t           state, state_nxt;
  logic             load, advance, last_beat;
  logic [DSIZE-1:0] beat;

  big_field_serializer #(.DSIZE(DSIZE), .FIELD_LEN(FIELD_LEN)) u_ser (
    .clock     (clock),
    .rst       (rst),
    .load      (load),
    .advance   (advance),
    .value     (value),
    .beat      (beat),
    .last_beat (last_beat)
  );

`ifdef GEN_BIG_FIELD_HEAD_ONLY_EN
  logic head_only;

  always_ff @(posedge clock or posedge rst) begin
    if (rst)       head_only <= 1'b0;
    else if (load) head_only <= value_last;
  end
`endif

  always_ff @(posedge clock or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    load          = 1'b0;
    advance       = 1'b0;
    value_ready   = 1'b0;
    s_axis_tready = 1'b0;
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = '0;
    m_axis_tlast  = 1'b0;
    case (state)
      IDLE: begin
        value_ready = 1'b1;
        if (value_valid) begin
          load      = 1'b1;
          state_nxt = HEAD;
        end
      end
      HEAD: begin
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = beat;
        advance       = m_axis_tready;
`ifdef GEN_BIG_FIELD_HEAD_ONLY_EN
        m_axis_tlast = last_beat && head_only;
        if (m_axis_tready && last_beat) state_nxt = head_only ? IDLE : BODY;
`else
        if (m_axis_tready && last_beat) state_nxt = BODY;
`endif
      end
      BODY: begin
        // Zero-latency passthrough; backpressure goes straight upstream.
        m_axis_tdata  = s_axis_tdata;
        m_axis_tvalid = s_axis_tvalid;
        m_axis_tlast  = s_axis_tlast;
        s_axis_tready = m_axis_tready;
        if (s_axis_tvalid && m_axis_tready && s_axis_tlast) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_gen_big_field_table_main.sv
// Directed vector bench for gen_big_field_table_main at DSIZE=8, FIELD_LEN=4.
module tb_gen_big_field_table_main;

  localparam int DSIZE     = 8;
  localparam int FIELD_LEN = 4;

  logic        clock = 1'b0;
  logic        rst;
  logic [31:0] value;
  logic        value_valid;
  logic        value_last;
  logic        value_ready;
  logic [7:0]  s_axis_tdata;
  logic        s_axis_tvalid, s_axis_tlast, s_axis_tready;
  logic [7:0]  m_axis_tdata;
  logic        m_axis_tvalid, m_axis_tlast, m_axis_tready;

  int checks = 0;
  int errors = 0;

  gen_big_field_table_main #(.DSIZE(DSIZE), .FIELD_LEN(FIELD_LEN)) dut (
    .clock         (clock),
    .rst           (rst),
    .value         (value),
    .value_valid   (value_valid),
`ifdef GEN_BIG_FIELD_HEAD_ONLY_EN
    .value_last    (value_last),
`endif
    .value_ready   (value_ready),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tready (m_axis_tready)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic        vv;
    logic [31:0] val;
    logic        vl;
    logic        stv;
    logic [7:0]  sd;
    logic        sl;
    logic        mr;
    logic        e_vr;
    logic        e_str;
    logic        e_mv;
    logic [7:0]  e_md;
    logic        e_ml;
  } vec_t;

  function automatic vec_t mk(input logic vv, input logic [31:0] val,
                              input logic stv, input logic [7:0] sd, input logic sl,
                              input logic mr, input logic e_vr, input logic e_str,
                              input logic e_mv, input logic [7:0] e_md, input logic e_ml);
    vec_t v;
    v.vv = vv; v.val = val; v.vl = 1'b0; v.stv = stv; v.sd = sd; v.sl = sl; v.mr = mr;
    v.e_vr = e_vr; v.e_str = e_str; v.e_mv = e_mv; v.e_md = e_md; v.e_ml = e_ml;
    return v;
  endfunction

  task automatic chk(input string nm, input int row, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %0h expected %0h", nm, row, act, exp);
    end
  endtask

  // Drive one cycle's inputs, check mid-cycle, then step past the edge.
  task automatic apply(input vec_t v, input int row);
    value_valid   = v.vv;
    value         = v.val;
    value_last    = v.vl;
    s_axis_tvalid = v.stv;
    s_axis_tdata  = v.sd;
    s_axis_tlast  = v.sl;
    m_axis_tready = v.mr;
    @(negedge clock);
    chk("value_ready", row, 32'(value_ready), 32'(v.e_vr));
    chk("s_tready",    row, 32'(s_axis_tready), 32'(v.e_str));
    chk("m_tvalid",    row, 32'(m_axis_tvalid), 32'(v.e_mv));
    chk("m_tdata",     row, 32'(m_axis_tdata), 32'(v.e_md));
    chk("m_tlast",     row, 32'(m_axis_tlast), 32'(v.e_ml));
    @(posedge clock);
    #1;
  endtask

  localparam logic [31:0] V1 = 32'hA1B2C3D4;
  localparam logic [31:0] V2 = 32'h55667788;

  vec_t vecs[$];
  vec_t hv;

  initial begin
    rst = 1'b1; value = '0; value_valid = 0; value_last = 0;
    s_axis_tdata = '0; s_axis_tvalid = 0; s_axis_tlast = 0; m_axis_tready = 0;
    #2;
    chk("rst value_ready", -1, 32'(value_ready), 32'd1);
    chk("rst s_tready",    -1, 32'(s_axis_tready), 32'd0);
    chk("rst m_tvalid",    -1, 32'(m_axis_tvalid), 32'd0);
    chk("rst m_tdata",     -1, 32'(m_axis_tdata), 32'd0);
    chk("rst m_tlast",     -1, 32'(m_axis_tlast), 32'd0);
    @(posedge clock); #1;
    rst = 1'b0;

    // Continuous ready: 6 consecutive beats.
    vecs.push_back(mk(1, V1, 0, 8'h00, 0, 1,  1, 0, 0, 8'h00, 0));
    vecs.push_back(mk(0, V1, 0, 8'h00, 0, 1,  0, 0, 1, 8'hA1, 0));
    vecs.push_back(mk(0, V1, 0, 8'h00, 0, 1,  0, 0, 1, 8'hB2, 0));
    vecs.push_back(mk(0, V1, 0, 8'h00, 0, 1,  0, 0, 1, 8'hC3, 0));
    vecs.push_back(mk(0, V1, 0, 8'h00, 0, 1,  0, 0, 1, 8'hD4, 0));
    vecs.push_back(mk(0, 0,  1, 8'h11, 0, 1,  0, 1, 1, 8'h11, 0));
    vecs.push_back(mk(0, 0,  1, 8'h22, 1, 1,  0, 1, 1, 8'h22, 1));
    vecs.push_back(mk(0, 0,  0, 8'h00, 0, 1,  1, 0, 0, 8'h00, 0));
    // Ready toggling 1,0,1,0: data/tlast held through stalls.
    vecs.push_back(mk(1, V1, 0, 8'h00, 0, 0,  1, 0, 0, 8'h00, 0));
    vecs.push_back(mk(0, 0,  0, 8'h00, 0, 1,  0, 0, 1, 8'hA1, 0));
    vecs.push_back(mk(0, 0,  0, 8'h00, 0, 0,  0, 0, 1, 8'hB2, 0));
    vecs.push_back(mk(0, 0,  0, 8'h00, 0, 1,  0, 0, 1, 8'hB2, 0));
    vecs.push_back(mk(0, 0,  0, 8'h00, 0, 0,  0, 0, 1, 8'hC3, 0));
    vecs.push_back(mk(0, 0,  0, 8'h00, 0, 1,  0, 0, 1, 8'hC3, 0));
    vecs.push_back(mk(0, 0,  0, 8'h00, 0, 0,  0, 0, 1, 8'hD4, 0));
    vecs.push_back(mk(0, 0,  0, 8'h00, 0, 1,  0, 0, 1, 8'hD4, 0));
    vecs.push_back(mk(0, 0,  1, 8'h11, 0, 0,  0, 0, 1, 8'h11, 0));
    vecs.push_back(mk(0, 0,  1, 8'h11, 0, 1,  0, 1, 1, 8'h11, 0));
    vecs.push_back(mk(0, 0,  1, 8'h22, 1, 0,  0, 0, 1, 8'h22, 1));
    vecs.push_back(mk(0, 0,  1, 8'h22, 1, 1,  0, 1, 1, 8'h22, 1));
    vecs.push_back(mk(0, 0,  0, 8'h00, 0, 1,  1, 0, 0, 8'h00, 0));
    // Payload offered early stalls until BODY.
    vecs.push_back(mk(0, 0,  1, 8'h11, 0, 1,  1, 0, 0, 8'h00, 0));
    vecs.push_back(mk(0, 0,  1, 8'h11, 0, 1,  1, 0, 0, 8'h00, 0));
    vecs.push_back(mk(0, 0,  1, 8'h11, 0, 1,  1, 0, 0, 8'h00, 0));
    vecs.push_back(mk(1, V1, 1, 8'h11, 0, 1,  1, 0, 0, 8'h00, 0));
    vecs.push_back(mk(0, 0,  1, 8'h11, 0, 1,  0, 0, 1, 8'hA1, 0));
    vecs.push_back(mk(0, 0,  1, 8'h11, 0, 1,  0, 0, 1, 8'hB2, 0));
    vecs.push_back(mk(0, 0,  1, 8'h11, 0, 1,  0, 0, 1, 8'hC3, 0));
    vecs.push_back(mk(0, 0,  1, 8'h11, 0, 1,  0, 0, 1, 8'hD4, 0));
    vecs.push_back(mk(0, 0,  1, 8'h11, 0, 1,  0, 1, 1, 8'h11, 0));
    vecs.push_back(mk(0, 0,  1, 8'h22, 1, 1,  0, 1, 1, 8'h22, 1));
    vecs.push_back(mk(0, 0,  0, 8'h00, 0, 1,  1, 0, 0, 8'h00, 0));
`ifdef GEN_BIG_FIELD_HEAD_ONLY_EN
    // Head-only frame: tlast on D4, payload left untouched.
    hv = mk(1, V1, 1, 8'h33, 0, 1,  1, 0, 0, 8'h00, 0); hv.vl = 1'b1;
    vecs.push_back(hv);
    vecs.push_back(mk(0, 0,  1, 8'h33, 0, 1,  0, 0, 1, 8'hA1, 0));
    vecs.push_back(mk(0, 0,  1, 8'h33, 0, 1,  0, 0, 1, 8'hB2, 0));
    vecs.push_back(mk(0, 0,  1, 8'h33, 0, 1,  0, 0, 1, 8'hC3, 0));
    vecs.push_back(mk(0, 0,  1, 8'h33, 0, 1,  0, 0, 1, 8'hD4, 1));
    vecs.push_back(mk(0, 0,  1, 8'h33, 0, 1,  1, 0, 0, 8'h00, 0));
    vecs.push_back(mk(0, 0,  0, 8'h00, 0, 1,  1, 0, 0, 8'h00, 0));
`endif
    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

    // Back-to-back with value_valid held: one IDLE gap, second value latched there.
    apply(mk(1, V1, 0, 8'h00, 0, 1,  1, 0, 0, 8'h00, 0), 100);
    apply(mk(1, V2, 0, 8'h00, 0, 1,  0, 0, 1, 8'hA1, 0), 101);
    apply(mk(1, V2, 0, 8'h00, 0, 1,  0, 0, 1, 8'hB2, 0), 102);
    apply(mk(1, V2, 0, 8'h00, 0, 1,  0, 0, 1, 8'hC3, 0), 103);
    apply(mk(1, V2, 0, 8'h00, 0, 1,  0, 0, 1, 8'hD4, 0), 104);
    apply(mk(1, V2, 1, 8'h99, 1, 1,  0, 1, 1, 8'h99, 1), 105);
    apply(mk(1, V2, 0, 8'h00, 0, 1,  1, 0, 0, 8'h00, 0), 106);
    apply(mk(0, 0,  0, 8'h00, 0, 1,  0, 0, 1, 8'h55, 0), 107);
    apply(mk(0, 0,  0, 8'h00, 0, 1,  0, 0, 1, 8'h66, 0), 108);
    apply(mk(0, 0,  0, 8'h00, 0, 1,  0, 0, 1, 8'h77, 0), 109);
    apply(mk(0, 0,  0, 8'h00, 0, 1,  0, 0, 1, 8'h88, 0), 110);
    apply(mk(0, 0,  1, 8'hAA, 1, 1,  0, 1, 1, 8'hAA, 1), 111);
    apply(mk(0, 0,  0, 8'h00, 0, 1,  1, 0, 0, 8'h00, 0), 112);

    // Reset after header beat B2 aborts the frame.
    apply(mk(1, V1, 0, 8'h00, 0, 1,  1, 0, 0, 8'h00, 0), 200);
    apply(mk(0, 0,  0, 8'h00, 0, 1,  0, 0, 1, 8'hA1, 0), 201);
    apply(mk(0, 0,  0, 8'h00, 0, 1,  0, 0, 1, 8'hB2, 0), 202);
    rst = 1'b1;
    #2;
    chk("midrst m_tvalid",    202, 32'(m_axis_tvalid), 32'd0);
    chk("midrst value_ready", 202, 32'(value_ready), 32'd1);
    chk("midrst m_tdata",     202, 32'(m_axis_tdata), 32'd0);
    @(posedge clock); #1;
    rst = 1'b0;
    apply(mk(1, 32'h01020304, 0, 8'h00, 0, 1,  1, 0, 0, 8'h00, 0), 203);
    apply(mk(0, 0,  0, 8'h00, 0, 1,  0, 0, 1, 8'h01, 0), 204);
    apply(mk(0, 0,  0, 8'h00, 0, 1,  0, 0, 1, 8'h02, 0), 205);
    apply(mk(0, 0,  0, 8'h00, 0, 1,  0, 0, 1, 8'h03, 0), 206);
    apply(mk(0, 0,  0, 8'h00, 0, 1,  0, 0, 1, 8'h04, 0), 207);
    apply(mk(0, 0,  1, 8'h5A, 1, 1,  0, 1, 1, 8'h5A, 1), 208);
    apply(mk(0, 0,  0, 8'h00, 0, 1,  1, 0, 0, 8'h00, 0), 209);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
